// File: rtl/keccak_sponge.sv
// Keccak sponge controller: absorbs 32-bit message words into the rate part
// of a 1600-bit state, applies SHA-3 style padding (0x06 ... 0x80), hands the
// state to an external Keccak-f[1600] core and squeezes out the digest words.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   msg_valid_i/ready_o   message word handshake
//   msg_data_i            message word, byte n at bits [8n+7:8n]
//   msg_bytes_i           valid bytes in word (0..4, <4 only on last word)
//   msg_last_i            final word of message
//   perm_start_o          one-cycle start pulse to the permutation core
//   perm_din_o            sponge state presented to the core
//   perm_dout_i           permuted state returned by the core
//   perm_done_i           one-cycle pulse, perm_dout_i valid
//   dig_valid_o/ready_i   digest word handshake
//   dig_data_o            digest word
//   busy_o                high whenever not idle
module keccak_sponge #(
  parameter int unsigned RATE_WORDS   = 34,
  parameter int unsigned DIGEST_WORDS = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          msg_valid_i,
  output logic          msg_ready_o,
  input  logic [31:0]   msg_data_i,
  input  logic [2:0]    msg_bytes_i,
  input  logic          msg_last_i,
  output logic          perm_start_o,
  output logic [1599:0] perm_din_o,
  input  logic [1599:0] perm_dout_i,
  input  logic          perm_done_i,
  output logic          dig_valid_o,
  output logic [31:0]   dig_data_o,
  input  logic          dig_ready_i,
  output logic          busy_o
);

  localparam int unsigned STATE_W    = 1600;
  localparam int unsigned IDX_W      = 6;   // word index, up to 49 words
  localparam int unsigned POS_W      = 8;   // byte position inside the rate
  localparam int unsigned RATE_BYTES = 4 * RATE_WORDS;
  localparam int unsigned LAST_BIT   = 8 * (RATE_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ABSORB,
    ST_PERM,
    ST_PAD,
    ST_SQUEEZE
  } fsm_e;

  fsm_e               fsm_q, fsm_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic [IDX_W-1:0]   widx_q, widx_d;
  logic [IDX_W-1:0]   sidx_q, sidx_d;
  logic               final_q, final_d;
  logic               pad_next_q, pad_next_d;
  logic               perm_start_q, perm_start_d;
  logic               msg_ready_q, msg_ready_d;
  logic               busy_q, busy_d;
  logic               dig_valid_q, dig_valid_d;
  logic [31:0]        dig_data_q, dig_data_d;

  logic [2:0]         nbytes;
  logic [31:0]        masked;
  logic [POS_W-1:0]   pad_pos;

  // Word preparation: clamp byte count, zero bytes beyond it, locate pad byte
  always_comb begin
    nbytes = (msg_bytes_i > 3'd4) ? 3'd4 : msg_bytes_i;
    masked = '0;
    for (int n = 0; n < 4; n++) begin
      if (3'(n) < nbytes) begin
        masked[8*n +: 8] = msg_data_i[8*n +: 8];
      end
    end
    pad_pos = {widx_q, 2'b00} + POS_W'(nbytes);
  end

  // Next-state and registered-output logic
  always_comb begin
    fsm_d      = fsm_q;
    state_d    = state_q;
    widx_d     = widx_q;
    sidx_d     = sidx_q;
    final_d    = final_q;
    pad_next_d = pad_next_q;

    case (fsm_q)
      ST_IDLE, ST_ABSORB: begin
        if (msg_valid_i && msg_ready_q) begin
          state_d[{widx_q, 5'b0} +: 32] = state_q[{widx_q, 5'b0} +: 32] ^ masked;
          if (msg_last_i) begin
            widx_d = '0;
            fsm_d  = ST_PERM;
            if (pad_pos < POS_W'(RATE_BYTES)) begin
              // Pad fits in this block; both XORs land on one byte if p is the last
              state_d[{pad_pos, 3'b0} +: 8] = state_d[{pad_pos, 3'b0} +: 8] ^ 8'h06;
              state_d[LAST_BIT +: 8]        = state_d[LAST_BIT +: 8] ^ 8'h80;
              final_d                       = 1'b1;
            end else begin
              // Block exactly full: padding goes into an extra block after PERM
              pad_next_d = 1'b1;
              final_d    = 1'b0;
            end
          end else if (widx_q == IDX_W'(RATE_WORDS - 1)) begin
            widx_d  = '0;
            final_d = 1'b0;
            fsm_d   = ST_PERM;
          end else begin
            widx_d = widx_q + IDX_W'(1);
            fsm_d  = ST_ABSORB;
          end
        end
      end

      ST_PERM: begin
        if (perm_done_i) begin
          state_d = perm_dout_i;
          if (pad_next_q) begin
            fsm_d = ST_PAD;
          end else if (final_q) begin
            fsm_d = ST_SQUEEZE;
          end else begin
            fsm_d = ST_ABSORB;
          end
        end
      end

      ST_PAD: begin
        state_d[7:0]           = state_q[7:0] ^ 8'h06;
        state_d[LAST_BIT +: 8] = state_q[LAST_BIT +: 8] ^ 8'h80;
        pad_next_d             = 1'b0;
        final_d                = 1'b1;
        fsm_d                  = ST_PERM;
      end

      ST_SQUEEZE: begin
        if (dig_ready_i) begin
          if (sidx_q == IDX_W'(DIGEST_WORDS - 1)) begin
            fsm_d      = ST_IDLE;
            state_d    = '0;
            widx_d     = '0;
            sidx_d     = '0;
            final_d    = 1'b0;
            pad_next_d = 1'b0;
          end else begin
            sidx_d = sidx_q + IDX_W'(1);
          end
        end
      end

      default: fsm_d = ST_IDLE;
    endcase

    // Outputs are registered copies of what the next cycle will present
    perm_start_d = (fsm_d == ST_PERM) && (fsm_q != ST_PERM);
    msg_ready_d  = (fsm_d == ST_IDLE) || (fsm_d == ST_ABSORB);
    busy_d       = (fsm_d != ST_IDLE);
    dig_valid_d  = (fsm_d == ST_SQUEEZE);
    dig_data_d   = state_d[{sidx_d, 5'b0} +: 32];
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q        <= ST_IDLE;
      state_q      <= '0;
      widx_q       <= '0;
      sidx_q       <= '0;
      final_q      <= 1'b0;
      pad_next_q   <= 1'b0;
      perm_start_q <= 1'b0;
      msg_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      dig_valid_q  <= 1'b0;
      dig_data_q   <= '0;
    end else begin
      fsm_q        <= fsm_d;
      state_q      <= state_d;
      widx_q       <= widx_d;
      sidx_q       <= sidx_d;
      final_q      <= final_d;
      pad_next_q   <= pad_next_d;
      perm_start_q <= perm_start_d;
      msg_ready_q  <= msg_ready_d;
      busy_q       <= busy_d;
      dig_valid_q  <= dig_valid_d;
      dig_data_q   <= dig_data_d;
    end
  end

  assign msg_ready_o  = msg_ready_q;
  assign perm_start_o = perm_start_q;
  assign perm_din_o   = state_q;
  assign dig_valid_o  = dig_valid_q;
  assign dig_data_o   = dig_data_q;
  assign busy_o       = busy_q;

endmodule
